// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared types and encodings for the stack pointer unit
package sp_pkg;

    // Fault FSM states: normal operation, latched overflow, latched underflow
    typedef enum logic [1:0] {
        SP_RUN = 2'd0,
        SP_OVF = 2'd1,
        SP_UNF = 2'd2
    } sp_state_e;

    // cfg_sel encodings for the bound register write port
    localparam logic SP_CFG_BASE  = 1'b0;
    localparam logic SP_CFG_LIMIT = 1'b1;

endpackage

// File: rtl/sp_fault_fsm.sv
// rtl/sp_fault_fsm.sv - sticky overflow/underflow fault state machine
module sp_fault_fsm
    import sp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push_fault,
    input  logic      pop_fault,
    input  logic      fault_clear,
    output sp_state_e state,
    output logic      overflow,
    output logic      underflow
);

    sp_state_e state_q;
    logic      overflow_q;
    logic      underflow_q;

    // Faults only enter from RUN; only fault_clear leaves a fault state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SP_RUN;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                SP_RUN: begin
                    if (push_fault) begin
                        state_q    <= SP_OVF;
                        overflow_q <= 1'b1;
                    end else if (pop_fault) begin
                        state_q     <= SP_UNF;
                        underflow_q <= 1'b1;
                    end
                end
                SP_OVF, SP_UNF: begin
                    if (fault_clear) begin
                        state_q     <= SP_RUN;
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= SP_RUN;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - bounds-checked stack pointer with memory strobe (option: SP_SHADOW_EN)
module stack_pointer_unit
    import sp_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_SP    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_LIMIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_sp,
    input  logic             push,
    input  logic             pop,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             lock,
    input  logic             fault_clear,
    input  logic [WIDTH-1:0] sp_data_in,
`ifdef SP_SHADOW_EN
    input  logic             ctx_sel,
`endif
    output logic [WIDTH-1:0] sp_data_out,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic             overflow,
    output logic             underflow,
    output logic             fault,
    output logic             invalid_write
);

    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] limit_q;
    logic             mem_valid_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic             invalid_q;

    logic [WIDTH-1:0] sp_cur;
    logic [WIDTH-1:0] sp_d;
    logic             sp_wr;

    sp_state_e        fsm_state;
    logic             in_run;
    logic             load_acc;
    logic             op_push;
    logic             op_pop;
    logic             push_ok;
    logic             pop_ok;
    logic             push_fault;
    logic             pop_fault;
    logic             invalid_d;

    assign in_run   = (fsm_state == SP_RUN);
    assign load_acc = load_sp & ~lock;

    // A push or pop is only considered when no load wins the cycle and the unit is not faulted
    assign op_push    = ~load_acc & in_run & push & ~pop;
    assign op_pop     = ~load_acc & in_run & pop & ~push;
    assign push_ok    = op_push & (sp_cur != limit_q);
    assign push_fault = op_push & (sp_cur == limit_q);
    assign pop_ok     = op_pop & (sp_cur != base_q);
    assign pop_fault  = op_pop & (sp_cur == base_q);

    // Locked writes and push+pop collisions are rejected; one pulse covers all rejections in a cycle
    assign invalid_d = (lock & (load_sp | cfg_we)) | (~load_acc & in_run & push & pop);

    // Next SP value for the active context
    always_comb begin
        sp_d  = sp_cur;
        sp_wr = 1'b0;
        if (load_acc) begin
            sp_d  = sp_data_in;
            sp_wr = 1'b1;
        end else if (push_ok) begin
            sp_d  = sp_cur - 1'b1;
            sp_wr = 1'b1;
        end else if (pop_ok) begin
            sp_d  = sp_cur + 1'b1;
            sp_wr = 1'b1;
        end
    end

`ifdef SP_SHADOW_EN
    logic [WIDTH-1:0] sp0_q;
    logic [WIDTH-1:0] sp1_q;

    assign sp_cur = ctx_sel ? sp1_q : sp0_q;

    // Only the context selected this cycle is updated; the other one holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp0_q <= RESET_SP;
            sp1_q <= RESET_SP;
        end else if (sp_wr) begin
            if (ctx_sel) begin
                sp1_q <= sp_d;
            end else begin
                sp0_q <= sp_d;
            end
        end
    end
`else
    logic [WIDTH-1:0] sp_q;

    assign sp_cur = sp_q;

    // Single stack pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= RESET_SP;
        end else if (sp_wr) begin
            sp_q <= sp_d;
        end
    end
`endif

    // Bound registers; lock blocks writes, and the new value takes effect next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= RESET_SP;
            limit_q <= RESET_LIMIT;
        end else if (cfg_we && !lock) begin
            if (cfg_sel == SP_CFG_BASE) begin
                base_q <= cfg_data;
            end else begin
                limit_q <= cfg_data;
            end
        end
    end

    // Memory strobe: one-cycle pulse per accepted access; address and direction hold between accesses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            invalid_q   <= 1'b0;
        end else begin
            mem_valid_q <= push_ok | pop_ok;
            invalid_q   <= invalid_d;
            if (push_ok) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= sp_cur - 1'b1;
            end else if (pop_ok) begin
                mem_we_q   <= 1'b0;
                mem_addr_q <= sp_cur;
            end
        end
    end

    sp_fault_fsm u_fault_fsm (
        .clk         (clk),
        .reset       (reset),
        .push_fault  (push_fault),
        .pop_fault   (pop_fault),
        .fault_clear (fault_clear),
        .state       (fsm_state),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    assign sp_data_out   = sp_cur;
    assign mem_valid     = mem_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign fault         = overflow | underflow;
    assign invalid_write = invalid_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb/tb_stack_pointer_unit.sv - self-checking bench for stack_pointer_unit (covers SP_SHADOW_EN when defined)
module tb_stack_pointer_unit;

    localparam int          W      = 16;
    localparam logic [15:0] R_SP   = 16'h00FF;
    localparam logic [15:0] R_LIM  = 16'h00F0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_sp = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_sel = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic          lock = 1'b0;
    logic          fault_clear = 1'b0;
    logic [W-1:0]  sp_data_in = '0;
`ifdef SP_SHADOW_EN
    logic          ctx_sel = 1'b0;
`endif
    logic [W-1:0]  sp_data_out;
    logic          mem_valid;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic          overflow;
    logic          underflow;
    logic          fault;
    logic          invalid_write;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_pointer_unit #(
        .WIDTH       (W),
        .RESET_SP    (R_SP),
        .RESET_LIMIT (R_LIM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_sp       (load_sp),
        .push          (push),
        .pop           (pop),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .lock          (lock),
        .fault_clear   (fault_clear),
        .sp_data_in    (sp_data_in),
`ifdef SP_SHADOW_EN
        .ctx_sel       (ctx_sel),
`endif
        .sp_data_out   (sp_data_out),
        .mem_valid     (mem_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .overflow      (overflow),
        .underflow     (underflow),
        .fault         (fault),
        .invalid_write (invalid_write)
    );

    typedef struct {
        string       name;
        logic        ld, psh, pp, cwe, csel;
        logic [15:0] cdata;
        logic        lk, fc;
        logic [15:0] din;
        logic [15:0] e_sp;
        logic        e_mv, e_we;
        logic [15:0] e_addr;
        logic        e_ovf, e_unf, e_inv;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(string n, logic ld, logic psh, logic pp, logic cwe, logic csel,
                                logic [15:0] cdata, logic lk, logic fc, logic [15:0] din,
                                logic [15:0] e_sp, logic e_mv, logic e_we, logic [15:0] e_addr,
                                logic e_ovf, logic e_unf, logic e_inv);
        vec_t v;
        v.name = n; v.ld = ld; v.psh = psh; v.pp = pp; v.cwe = cwe; v.csel = csel;
        v.cdata = cdata; v.lk = lk; v.fc = fc; v.din = din;
        v.e_sp = e_sp; v.e_mv = e_mv; v.e_we = e_we; v.e_addr = e_addr;
        v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_inv = e_inv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input vec_t e);
        check({e.name, ".sp"},       32'(sp_data_out),   32'(e.e_sp));
        check({e.name, ".mem_valid"}, 32'(mem_valid),    32'(e.e_mv));
        check({e.name, ".mem_we"},   32'(mem_we),        32'(e.e_we));
        check({e.name, ".mem_addr"}, 32'(mem_addr),      32'(e.e_addr));
        check({e.name, ".overflow"}, 32'(overflow),      32'(e.e_ovf));
        check({e.name, ".underflow"}, 32'(underflow),    32'(e.e_unf));
        check({e.name, ".fault"},    32'(fault),         32'(e.e_ovf | e.e_unf));
        check({e.name, ".invalid"},  32'(invalid_write), 32'(e.e_inv));
    endtask

    task automatic idle_inputs();
        load_sp = 0; push = 0; pop = 0; cfg_we = 0; cfg_sel = 0; cfg_data = '0;
        lock = 0; fault_clear = 0; sp_data_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t e;
        //        name            ld psh pp cwe cs cdata     lk fc din        sp        mv we addr      ov un inv
        vecs.push_back(mk("push1",        0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00FE,1,1,16'h00FE,0,0,0));
        vecs.push_back(mk("idle1",        0,0,0,0,0,16'h0000,0,0,16'h0000, 16'h00FE,0,1,16'h00FE,0,0,0));
        vecs.push_back(mk("pop1",         0,0,1,0,0,16'h0000,0,0,16'h0000, 16'h00FF,1,0,16'h00FE,0,0,0));
        vecs.push_back(mk("pop_unf",      0,0,1,0,0,16'h0000,0,0,16'h0000, 16'h00FF,0,0,16'h00FE,0,1,0));
        vecs.push_back(mk("push_in_unf",  0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00FF,0,0,16'h00FE,0,1,0));
        vecs.push_back(mk("clr_unf",      0,0,0,0,0,16'h0000,0,1,16'h0000, 16'h00FF,0,0,16'h00FE,0,0,0));
        vecs.push_back(mk("push2",        0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00FE,1,1,16'h00FE,0,0,0));
        vecs.push_back(mk("push_pop",     0,1,1,0,0,16'h0000,0,0,16'h0000, 16'h00FE,0,1,16'h00FE,0,0,1));
        vecs.push_back(mk("idle2",        0,0,0,0,0,16'h0000,0,0,16'h0000, 16'h00FE,0,1,16'h00FE,0,0,0));
        vecs.push_back(mk("lock_load",    1,0,0,0,0,16'h0000,1,0,16'h1234, 16'h00FE,0,1,16'h00FE,0,0,1));
        vecs.push_back(mk("lock_ld_cfg",  1,0,0,1,1,16'h00FD,1,0,16'h1234, 16'h00FE,0,1,16'h00FE,0,0,1));
        vecs.push_back(mk("idle3",        0,0,0,0,0,16'h0000,0,0,16'h0000, 16'h00FE,0,1,16'h00FE,0,0,0));
        vecs.push_back(mk("load_push",    1,1,0,0,0,16'h0000,0,0,16'h0080, 16'h0080,0,1,16'h00FE,0,0,0));
        vecs.push_back(mk("load_f1",      1,0,0,0,0,16'h0000,0,0,16'h00F1, 16'h00F1,0,1,16'h00FE,0,0,0));
        vecs.push_back(mk("push_to_lim",  0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00F0,1,1,16'h00F0,0,0,0));
        vecs.push_back(mk("push_ovf",     0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00F0,0,1,16'h00F0,1,0,0));
        vecs.push_back(mk("pop_in_ovf",   0,0,1,0,0,16'h0000,0,0,16'h0000, 16'h00F0,0,1,16'h00F0,1,0,0));
        vecs.push_back(mk("load_in_ovf",  1,0,0,0,0,16'h0000,0,0,16'h00F5, 16'h00F5,0,1,16'h00F0,1,0,0));
        vecs.push_back(mk("clr_ovf",      0,0,0,0,0,16'h0000,0,1,16'h0000, 16'h00F5,0,1,16'h00F0,0,0,0));
        vecs.push_back(mk("cfg_lim_push", 0,1,0,1,1,16'h00F4,0,0,16'h0000, 16'h00F4,1,1,16'h00F4,0,0,0));
        vecs.push_back(mk("push_new_lim", 0,1,0,0,0,16'h0000,0,0,16'h0000, 16'h00F4,0,1,16'h00F4,1,0,0));
        vecs.push_back(mk("clr_ovf2",     0,0,0,0,0,16'h0000,0,1,16'h0000, 16'h00F4,0,1,16'h00F4,0,0,0));
        vecs.push_back(mk("cfg_base",     0,0,0,1,0,16'h00F5,0,0,16'h0000, 16'h00F4,0,1,16'h00F4,0,0,0));
        vecs.push_back(mk("pop_new_base", 0,0,1,0,0,16'h0000,0,0,16'h0000, 16'h00F5,1,0,16'h00F4,0,0,0));
        vecs.push_back(mk("pop_unf2",     0,0,1,0,0,16'h0000,0,0,16'h0000, 16'h00F5,0,0,16'h00F4,0,1,0));
        vecs.push_back(mk("clr_unf2",     0,0,0,0,0,16'h0000,0,1,16'h0000, 16'h00F5,0,0,16'h00F4,0,0,0));
        vecs.push_back(mk("clr_in_run",   0,0,0,0,0,16'h0000,0,1,16'h0000, 16'h00F5,0,0,16'h00F4,0,0,0));

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all(mk("reset", 0,0,0,0,0,16'h0,0,0,16'h0, R_SP,0,0,16'h0000,0,0,0));

        // Table-driven sequence: expectation queued at drive time, compared after the edge
        foreach (vecs[i]) begin
            @(negedge clk);
            load_sp = vecs[i].ld; push = vecs[i].psh; pop = vecs[i].pp;
            cfg_we = vecs[i].cwe; cfg_sel = vecs[i].csel; cfg_data = vecs[i].cdata;
            lock = vecs[i].lk; fault_clear = vecs[i].fc; sp_data_in = vecs[i].din;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_all(e);
        end

        // Fill to the limit: 15 pushes from 0x00FF reach 0x00F0, the 16th overflows
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            push = 1'b1;
            @(posedge clk);
            #1;
            if (i <= 15) begin
                check($sformatf("fill%0d.sp", i), 32'(sp_data_out), 32'(R_SP - 16'(i)));
                check($sformatf("fill%0d.addr", i), 32'(mem_addr), 32'(R_SP - 16'(i)));
                check($sformatf("fill%0d.mv", i), 32'(mem_valid), 32'd1);
            end else begin
                check("fill16.sp", 32'(sp_data_out), 32'h00F0);
                check("fill16.ovf", 32'(overflow), 32'd1);
                check("fill16.mv", 32'(mem_valid), 32'd0);
            end
        end

        // Asynchronous reset in the middle of an access drops mem_valid immediately
        do_reset();
        @(negedge clk);
        push = 1'b1;
        @(posedge clk);
        #1;
        check("async.mv_before", 32'(mem_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async.mv_after", 32'(mem_valid), 32'd0);
        check("async.sp_after", 32'(sp_data_out), 32'(R_SP));
        check("async.addr_after", 32'(mem_addr), 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

`ifdef SP_SHADOW_EN
        // Two contexts share bounds but keep independent pointers
        do_reset();
        @(negedge clk);
        ctx_sel = 1'b0; push = 1'b1;
        @(posedge clk);
        #1;
        check("ctx0.push_sp", 32'(sp_data_out), 32'h00FE);
        @(negedge clk);
        push = 1'b0; ctx_sel = 1'b1;
        #1;
        check("ctx1.read_sp", 32'(sp_data_out), 32'h00FF);
        @(negedge clk);
        ctx_sel = 1'b0;
        #1;
        check("ctx0.read_back", 32'(sp_data_out), 32'h00FE);
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1;
        check("ctx0.pop_sp", 32'(sp_data_out), 32'h00FF);
        check("ctx0.pop_addr", 32'(mem_addr), 32'h00FE);
        @(negedge clk);
        pop = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Parametrised stack-pointer unit for the CPU datapath. It holds the active stack pointer and bounds-checks every push and pop against programmable base and limit registers. It issues a registered memory address strobe for each stack access and latches overflow and underflow faults until software clears them. It replaces the single-register pointer and sits between the control unit and the data-memory address mux.

## Interface
- WIDTH, 16, pointer, base, limit and address width
- RESET_SP, {WIDTH{1'b1}} truncated to WIDTH, reset value of SP and base
- RESET_LIMIT, 0, reset value of limit
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- load_sp  in  1  load SP from sp_data_in
- push  in  1  pre-decrement push request
- pop  in  1  post-increment pop request
- cfg_we  in  1  write a bound register
- cfg_sel  in  1  bound select: 0 = base, 1 = limit
- cfg_data  in  WIDTH  bound write data
- lock  in  1  write-protect for load_sp and cfg_we
- fault_clear  in  1  clear latched fault
- sp_data_in  in  WIDTH  SP load data
- sp_data_out  out  WIDTH  current SP
- mem_valid  out  1  registered stack access strobe
- mem_we  out  1  1 = push (write), 0 = pop (read); valid with mem_valid
- mem_addr  out  WIDTH  access address
- overflow  out  1  sticky push-past-limit fault
- underflow  out  1  sticky pop-past-base fault
- fault  out  1  overflow | underflow
- invalid_write  out  1  one-cycle pulse on a rejected request

## Operation
- The stack grows down. base is the empty-stack SP; limit is the lowest legal SP.
- **Push:** if SP != limit, then SP <= SP-1, mem_addr <= SP-1, mem_we <= 1, mem_valid <= 1. If SP == limit, SP is held and the FSM goes to OVF.
- **Pop:** if SP != base, then mem_addr <= SP, mem_we <= 0, mem_valid <= 1, SP <= SP+1. If SP == base, SP is held and the FSM goes to UNF.
- **Arithmetic:** modulo 2^WIDTH. Wrap is never reached legally because the bounds check happens first.
- **Priority per cycle:** load_sp > push/pop.
  - If load_sp is accepted, push and pop are ignored and produce no mem access.
  - push and pop asserted together is a no-op; it pulses invalid_write.
- **lock:** when high, load_sp and cfg_we are rejected (no state change) and invalid_write pulses. Both rejected together produce a single pulse.
- **cfg_we:** writes the selected bound. It is independent of SP operations in the same cycle, and the new bound is used from the next cycle.
- **FSM states:** RUN, OVF, UNF.
  - RUN→OVF on a faulting push; RUN→UNF on a faulting pop.
  - In OVF or UNF, push and pop are ignored: no SP change, no mem access, no invalid_write.
  - fault_clear in OVF or UNF → RUN on the next edge. fault_clear in RUN has no effect.
  - load_sp (unlocked) is honoured in every state and does not clear the fault.
- overflow = (state==OVF), underflow = (state==UNF).

## Timing
- **Reset values:** sp_data_out=RESET_SP, base=RESET_SP, limit=RESET_LIMIT, state=RUN, mem_valid=0, mem_we=0, mem_addr=0, invalid_write=0.
- Reset mid-operation aborts everything; mem_valid drops asynchronously.
- All outputs are registered. A request at edge N is reflected in SP, mem_* and the fault flags after edge N.
- mem_valid is a single-cycle pulse per accepted push or pop. Back-to-back push/pop sustain one access per cycle.
- invalid_write is high for exactly the cycle after each rejected request.
- The fault is visible the cycle after the offending request. fault_clear takes one cycle.

## Configuration
- **SP_SHADOW_EN defined:** adds input ctx_sel (1 bit) and a second SP register, with both SPs reset to RESET_SP.
  - ctx_sel selects which SP is read, loaded, pushed and popped. The other SP holds.
  - Base, limit and the FSM are shared.
  - ctx_sel is sampled with the request in the same cycle.
- **SP_SHADOW_EN undefined:** ctx_sel port is absent and there is a single SP.

## Structure
- Package sp_pkg holds:
  - the state enum (SP_RUN, SP_OVF, SP_UNF);
  - cfg_sel encodings SP_CFG_BASE=0 and SP_CFG_LIMIT=1.
- Sub-module sp_fault_fsm holds the state register and next-state logic.
  - Inputs: push_fault, pop_fault, fault_clear.
  - Outputs: state, overflow, underflow.
- The top level holds the SP, bound registers, bounds comparators and mem_* registers.

## Test plan
All scenarios use WIDTH=16, RESET_SP=0x00FF, RESET_LIMIT=0x00F0.
- **Reset then push:** reset, then push → sp=0x00FE, mem_addr=0x00FE, mem_we=1, mem_valid=1 for one cycle.
- **Underflow:** pop at reset → sp stays 0x00FF, underflow=1, no mem_valid. A further push is ignored. fault_clear → underflow=0, then push works.
- **Overflow:** 15 pushes reach 0x00F0. The 16th push → overflow=1 and sp=0x00F0.
- **Lock:** lock=1 with load_sp and sp_data_in=0x1234 → sp unchanged and invalid_write is a 1-cycle pulse. Same with cfg_we → bound unchanged, same pulse.
- **Simultaneous requests:** push+pop together → sp unchanged, invalid_write pulses. load_sp=0x0080 with push → sp=0x0080, no mem_valid.
- **SP_SHADOW_EN:** push with ctx_sel=0, then ctx_sel=1 → second SP reads 0x00FF. Popping back on ctx 0 restores 0x00FF.
